// File: rtl/jt5205_adpcm_dec.sv
// JT5205 ADPCM decode stage: per cen_lo strobe, one nibble updates the
// 12-bit signed output through the MSM5205 step-size/index algorithm.
module jt5205_adpcm_dec #(
    parameter int SW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen_lo,
    input  logic          chip_rst,
    input  logic [3:0]    din,
    output logic [SW-1:0] sound,
    output logic          snd_vld,
    output logic          overrun
);

    logic [5:0]         idx_q, idx_d;
    logic signed [11:0] sig_q, sig_d;
    logic               st1_q, st1_d;
    logic [3:0]         nib_q, nib_d;
    logic [10:0]        step_q, step_d;
    logic               snd_vld_q, snd_vld_d;
    logic               overrun_q, overrun_d;

    logic [11:0]        delta;
    logic signed [13:0] sum;
    logic signed [11:0] sig_sat;
    logic signed [7:0]  idx_adj;
    logic signed [7:0]  idx_sum;
    logic [5:0]         idx_sat;

    function automatic logic [10:0] step_lut(input logic [5:0] i);
        logic [10:0] s;
        unique case (i)
            6'd0:  s = 11'd16;
            6'd1:  s = 11'd17;
            6'd2:  s = 11'd19;
            6'd3:  s = 11'd21;
            6'd4:  s = 11'd23;
            6'd5:  s = 11'd25;
            6'd6:  s = 11'd28;
            6'd7:  s = 11'd31;
            6'd8:  s = 11'd34;
            6'd9:  s = 11'd37;
            6'd10: s = 11'd41;
            6'd11: s = 11'd45;
            6'd12: s = 11'd50;
            6'd13: s = 11'd55;
            6'd14: s = 11'd60;
            6'd15: s = 11'd66;
            6'd16: s = 11'd73;
            6'd17: s = 11'd80;
            6'd18: s = 11'd88;
            6'd19: s = 11'd97;
            6'd20: s = 11'd107;
            6'd21: s = 11'd118;
            6'd22: s = 11'd130;
            6'd23: s = 11'd143;
            6'd24: s = 11'd157;
            6'd25: s = 11'd173;
            6'd26: s = 11'd190;
            6'd27: s = 11'd209;
            6'd28: s = 11'd230;
            6'd29: s = 11'd253;
            6'd30: s = 11'd279;
            6'd31: s = 11'd307;
            6'd32: s = 11'd337;
            6'd33: s = 11'd371;
            6'd34: s = 11'd408;
            6'd35: s = 11'd449;
            6'd36: s = 11'd494;
            6'd37: s = 11'd544;
            6'd38: s = 11'd598;
            6'd39: s = 11'd658;
            6'd40: s = 11'd724;
            6'd41: s = 11'd796;
            6'd42: s = 11'd876;
            6'd43: s = 11'd963;
            6'd44: s = 11'd1060;
            6'd45: s = 11'd1166;
            6'd46: s = 11'd1282;
            6'd47: s = 11'd1411;
            default: s = 11'd1552;
        endcase
        return s;
    endfunction

    always_comb begin
        delta = {4'd0, step_q[10:3]};
        if (nib_q[2]) delta = delta + {1'b0, step_q};
        if (nib_q[1]) delta = delta + {2'd0, step_q[10:1]};
        if (nib_q[0]) delta = delta + {3'd0, step_q[10:2]};
    end

    // Two guard bits: -2048 minus a full-scale delta must not wrap.
    always_comb begin
        if (nib_q[3]) sum = {{2{sig_q[11]}}, sig_q} - $signed({2'd0, delta});
        else          sum = {{2{sig_q[11]}}, sig_q} + $signed({2'd0, delta});
        if (sum > 14'sd2047)        sig_sat = 12'sh7FF;
        else if (sum < -14'sd2048)  sig_sat = 12'sh800;
        else                        sig_sat = sum[11:0];
    end

    always_comb begin
        unique case (nib_q[2:0])
            3'd4:    idx_adj = 8'sd2;
            3'd5:    idx_adj = 8'sd4;
            3'd6:    idx_adj = 8'sd6;
            3'd7:    idx_adj = 8'sd8;
            default: idx_adj = -8'sd1;
        endcase
        idx_sum = $signed({2'd0, idx_q}) + idx_adj;
        if (idx_sum < 8'sd0)       idx_sat = 6'd0;
        else if (idx_sum > 8'sd48) idx_sat = 6'd48;
        else                       idx_sat = idx_sum[5:0];
    end

    always_comb begin
        idx_d     = idx_q;
        sig_d     = sig_q;
        st1_d     = st1_q;
        nib_d     = nib_q;
        step_d    = step_q;
        snd_vld_d = 1'b0;
        overrun_d = 1'b0;
        if (chip_rst) begin
            idx_d = 6'd0;
            sig_d = 12'sd0;
            st1_d = 1'b0;
        end else if (st1_q) begin
            sig_d     = sig_sat;
            idx_d     = idx_sat;
            st1_d     = 1'b0;
            snd_vld_d = 1'b1;
            overrun_d = cen_lo;
        end else if (cen_lo) begin
            nib_d  = din;
            step_d = step_lut(idx_q);
            st1_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= 6'd0;
            sig_q     <= 12'sd0;
            st1_q     <= 1'b0;
            nib_q     <= 4'd0;
            step_q    <= 11'd0;
            snd_vld_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            sig_q     <= sig_d;
            st1_q     <= st1_d;
            nib_q     <= nib_d;
            step_q    <= step_d;
            snd_vld_q <= snd_vld_d;
            overrun_q <= overrun_d;
        end
    end

    assign sound   = sig_q;
    assign snd_vld = snd_vld_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_jt5205_adpcm_dec.sv
// Directed bench for jt5205_adpcm_dec: vector table plus hand sequences
// for saturation, index floor, overrun and chip_rst.
module tb_jt5205_adpcm_dec;

    logic        clk;
    logic        rst_n;
    logic        cen_lo;
    logic        chip_rst;
    logic [3:0]  din;
    logic [11:0] sound;
    logic        snd_vld;
    logic        overrun;

    int n_chk;
    int n_fail;

    jt5205_adpcm_dec dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen_lo   (cen_lo),
        .chip_rst (chip_rst),
        .din      (din),
        .sound    (sound),
        .snd_vld  (snd_vld),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] din;
        int         snd;
        int         idx;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int snd_i();
        return int'($signed(sound));
    endfunction

    // Called #1 after an edge; returns #1 after the edge where stage 2 lands.
    task automatic strobe(input logic [3:0] d);
        cen_lo = 1'b1;
        din    = d;
        @(posedge clk); #1;
        cen_lo = 1'b0;
        din    = 4'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_chip_rst();
        chip_rst = 1'b1;
        tick();
        chip_rst = 1'b0;
    endtask

    initial begin
        int vld_cnt;
        n_chk    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        cen_lo   = 1'b0;
        chip_rst = 1'b0;
        din      = 4'd0;

        vecs[0] = '{4'b0111, 30, 8};
        vecs[1] = '{4'b1000, 26, 7};
        vecs[2] = '{4'b0100, 60, 9};
        vecs[3] = '{4'b1011, 29, 8};
        vecs[4] = '{4'b0101, 75, 12};
        vecs[5] = '{4'b1110, -6, 18};

        #12;
        chk("rst_sound", snd_i(), 0);
        chk("rst_vld", int'(snd_vld), 0);
        chk("rst_ovr", int'(overrun), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        chk("idle_vld", int'(snd_vld), 0);

        for (int i = 0; i < 6; i++) begin
            strobe(vecs[i].din);
            chk($sformatf("vec%0d_vld", i), int'(snd_vld), 1);
            chk($sformatf("vec%0d_sound", i), snd_i(), vecs[i].snd);
            chk($sformatf("vec%0d_idx", i), int'(dut.idx_q), vecs[i].idx);
            chk($sformatf("vec%0d_ovr", i), int'(overrun), 0);
        end
        tick();
        chk("vld_one_cycle", int'(snd_vld), 0);

        for (int i = 0; i < 20; i++) strobe(4'b0111);
        chk("sat_pos_sound", snd_i(), 2047);
        chk("sat_pos_idx", int'(dut.idx_q), 48);
        strobe(4'b0111);
        chk("sat_pos_hold", snd_i(), 2047);
        for (int i = 0; i < 20; i++) strobe(4'b1111);
        chk("sat_neg_sound", snd_i(), -2048);
        chk("sat_neg_idx", int'(dut.idx_q), 48);
        strobe(4'b1111);
        chk("sat_neg_hold", snd_i(), -2048);

        pulse_chip_rst();
        chk("crst_sound", snd_i(), 0);
        chk("crst_idx", int'(dut.idx_q), 0);
        for (int i = 0; i < 3; i++) begin
            strobe(4'b0000);
            chk($sformatf("floor%0d_sound", i), snd_i(), 2 * (i + 1));
            chk($sformatf("floor%0d_idx", i), int'(dut.idx_q), 0);
        end

        pulse_chip_rst();
        cen_lo = 1'b1;
        din    = 4'd7;
        tick();
        din    = 4'd3;
        tick();
        cen_lo = 1'b0;
        chk("ovr_pulse", int'(overrun), 1);
        chk("ovr_vld", int'(snd_vld), 1);
        chk("ovr_sound", snd_i(), 30);
        vld_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vld_cnt += int'(snd_vld);
            chk($sformatf("ovr_single%0d", i), int'(overrun), 0);
        end
        chk("ovr_extra_vld", vld_cnt, 0);
        chk("ovr_sound_kept", snd_i(), 30);
        chk("ovr_idx", int'(dut.idx_q), 8);

        chip_rst = 1'b1;
        cen_lo   = 1'b1;
        din      = 4'd7;
        tick();
        chip_rst = 1'b0;
        cen_lo   = 1'b0;
        chk("crst_cen_sound", snd_i(), 0);
        chk("crst_cen_idx", int'(dut.idx_q), 0);
        chk("crst_cen_vld", int'(snd_vld), 0);
        tick();
        chk("crst_cen_vld2", int'(snd_vld), 0);
        chk("crst_cen_sound2", snd_i(), 0);

        strobe(4'b0111);
        chk("inflight_pre", snd_i(), 30);
        cen_lo = 1'b1;
        din    = 4'b0111;
        tick();
        cen_lo   = 1'b0;
        chip_rst = 1'b1;
        tick();
        chip_rst = 1'b0;
        chk("inflight_sound", snd_i(), 0);
        chk("inflight_vld", int'(snd_vld), 0);
        tick();
        chk("inflight_vld2", int'(snd_vld), 0);

        strobe(4'b0111);
        chk("post_crst_vld", int'(snd_vld), 1);
        chk("post_crst_sound", snd_i(), 30);
        chk("post_crst_idx", int'(dut.idx_q), 8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
